// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer; optional even parity via UART_RX_PARITY_EN.
// Byte lands 1 cycle after stop sample; no backpressure, unread byte is overwritten (overrun flagged).
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   input  logic       i_clr_rx_rdy,
   output logic [7:0] o_rx_data,
   output logic       o_rx_rdy,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_overrun
);

   localparam int CW = 16;
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state, state_nxt;
   logic            rx_s1, rx_s2, rx_prev;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            tick;
   logic            arm;
   logic            load_half, load_full, shift_en, stop_smp;
   logic            par_bad, deliver, frame_bad;

   assign tick = (baud_cnt == '0);
   assign arm  = rx_prev & ~rx_s2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (arm) state_nxt = START;
         START: if (tick) state_nxt = rx_s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:   if (tick && bit_cnt == 3'd7) state_nxt = PARITY;
         PARITY: if (tick) state_nxt = STOP;
`else
         DATA:   if (tick && bit_cnt == 3'd7) state_nxt = STOP;
`endif
         STOP:  if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   assign par_bad = ^{shreg, par_bit};
`else
   assign par_bad = 1'b0;
`endif

   always_comb begin
      load_half = (state == IDLE) && arm;
      load_full = 1'b0;
      shift_en  = (state == DATA) && tick;
      stop_smp  = (state == STOP) && tick;
      case (state)
         START:   load_full = tick && !rx_s2;
         DATA:    load_full = tick;
`ifdef UART_RX_PARITY_EN
         PARITY:  load_full = tick;
`endif
         default: load_full = 1'b0;
      endcase
      deliver   = stop_smp && rx_s2 && !par_bad;
      frame_bad = stop_smp && !rx_s2;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_s1       <= 1'b1;
         rx_s2       <= 1'b1;
         rx_prev     <= 1'b1;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         o_rx_data   <= '0;
         o_rx_rdy    <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         rx_s1   <= i_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         if (load_half)                     baud_cnt <= HALF_LOAD;
         else if (load_full)                baud_cnt <= FULL_LOAD;
         else if (state != IDLE && !tick)   baud_cnt <= baud_cnt - 1'b1;
         if (state == START)                bit_cnt <= '0;
         else if (shift_en)                 bit_cnt <= bit_cnt + 1'b1;
         if (shift_en)                      shreg <= {rx_s2, shreg[7:1]};
         // a byte completing in the same cycle as the clear keeps rdy set
         if (deliver) begin
            o_rx_data <= shreg;
            o_rx_rdy  <= 1'b1;
         end else if (i_clr_rx_rdy) begin
            o_rx_rdy  <= 1'b0;
         end
         o_overrun   <= deliver && o_rx_rdy;
         o_frame_err <= frame_bad;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         par_bit      <= 1'b0;
         o_parity_err <= 1'b0;
      end else begin
         if (state == PARITY && tick) par_bit <= rx_s2;
         o_parity_err <= stop_smp && par_bad;
      end
   end
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16; monitor checks every output event against queued expectations.
module tb_uart_rx;
   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 171;
`else
   localparam int LAT = 155;
`endif
   localparam logic [1:0] K_DLV = 2'd0, K_OVR = 2'd1, K_FRM = 2'd2, K_PAR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
      logic       rdy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_rx = 1'b1;
   logic       clr = 1'b0;
   logic [7:0] o_rx_data;
   logic       o_rx_rdy, o_frame_err, o_parity_err, o_overrun;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   frame_start = 0;
   exp_t sb[$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx(i_rx), .i_clr_rx_rdy(clr),
      .o_rx_data(o_rx_data), .o_rx_rdy(o_rx_rdy), .o_frame_err(o_frame_err),
      .o_parity_err(o_parity_err), .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor
   logic rdy_q = 1'b0, fe_q = 1'b0, pe_q = 1'b0, ov_q = 1'b0;
   always @(negedge clk) begin
      logic [1:0] kind;
      exp_t e;
      if (!rst) begin
         if (fe_q || pe_q || ov_q) begin
            checks++;
            if ((fe_q && o_frame_err) || (pe_q && o_parity_err) || (ov_q && o_overrun)) begin
               errors++;
               $display("FAIL pulse_width: flags fe=%0b pe=%0b ov=%0b still high, required one-cycle pulse",
                        o_frame_err, o_parity_err, o_overrun);
            end
         end
         if ((o_rx_rdy && !rdy_q) || o_overrun || o_frame_err || o_parity_err) begin
            kind = o_overrun ? K_OVR : o_frame_err ? K_FRM : o_parity_err ? K_PAR : K_DLV;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: kind %0d data %02h, required no event", kind, o_rx_data);
            end else begin
               e = sb.pop_front();
               if (kind != e.kind || o_rx_data != e.data || o_rx_rdy != e.rdy ||
                   (cyc - frame_start) != LAT) begin
                  errors++;
                  $display("FAIL event: kind %0d data %02h rdy %0b lat %0d, required kind %0d data %02h rdy %0b lat %0d",
                           kind, o_rx_data, o_rx_rdy, cyc - frame_start, e.kind, e.data, e.rdy, LAT);
               end
            end
         end
      end
      rdy_q = o_rx_rdy;
      fe_q  = o_frame_err;
      pe_q  = o_parity_err;
      ov_q  = o_overrun;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %02h, required %02h", name, act, req);
      end
   endtask

   task automatic hold();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
      @(posedge clk); #1;
      frame_start = cyc;
      i_rx = 1'b0; hold();
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i]; hold();
      end
`ifdef UART_RX_PARITY_EN
      i_rx = (^d) ^ par_flip; hold();
`endif
      i_rx = stop; hold();
      i_rx = 1'b1;
   endtask

   task automatic expect_ev(input logic [1:0] k, input logic [7:0] d, input logic r);
      exp_t e;
      e.kind = k; e.data = d; e.rdy = r;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(posedge clk); n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d events pending, required 0", name, sb.size());
         sb.delete();
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic clear_rdy(input string name);
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
      check(name, {7'd0, o_rx_rdy}, 8'h00);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data", o_rx_data, 8'h00);
      check("reset_rdy", {7'd0, o_rx_rdy}, 8'h00);
      check("reset_flags", {5'd0, o_frame_err, o_parity_err, o_overrun}, 8'h00);
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);

      // basic byte, held until cleared
      expect_ev(K_DLV, 8'hA5, 1'b1);
      send(8'hA5, 1'b1, 1'b0);
      drain("a5");
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("a5_held_rdy", {7'd0, o_rx_rdy}, 8'h01);
      clear_rdy("a5_clr");
      check("a5_data_after_clr", o_rx_data, 8'hA5);

      // false start then good byte
      @(posedge clk); #1 i_rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 i_rx = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("false_start_rdy", {7'd0, o_rx_rdy}, 8'h00);
      expect_ev(K_DLV, 8'h55, 1'b1);
      send(8'h55, 1'b1, 1'b0);
      drain("after_false_start");
      clear_rdy("55_clr");

      // framing error keeps old data, then a good byte
      expect_ev(K_FRM, 8'h55, 1'b0);
      send(8'h3C, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      expect_ev(K_DLV, 8'h55, 1'b1);
      send(8'h55, 1'b1, 1'b0);
      drain("frame_err");
      clear_rdy("frm_clr");

      // overrun on back-to-back bytes
      expect_ev(K_DLV, 8'h11, 1'b1);
      send(8'h11, 1'b1, 1'b0);
      expect_ev(K_OVR, 8'h22, 1'b1);
      send(8'h22, 1'b1, 1'b0);
      drain("overrun");
      @(negedge clk);
      check("overrun_data", o_rx_data, 8'h22);
      clear_rdy("ovr_clr");

      // reset during bit 4 of 0xFF
      @(posedge clk); #1 i_rx = 1'b0;
      hold();
      i_rx = 1'b1;
      repeat (4 * CPB + CPB / 2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_data", o_rx_data, 8'h00);
      check("midreset_rdy", {7'd0, o_rx_rdy}, 8'h00);
      repeat (2 * CPB) @(posedge clk);
      expect_ev(K_DLV, 8'h80, 1'b1);
      send(8'h80, 1'b1, 1'b0);
      drain("after_reset");
      check("after_reset_data", o_rx_data, 8'h80);
      clear_rdy("80_clr");

`ifdef UART_RX_PARITY_EN
      expect_ev(K_PAR, 8'h80, 1'b0);
      send(8'h07, 1'b1, 1'b1);
      drain("parity_bad");
      expect_ev(K_DLV, 8'h07, 1'b1);
      send(8'h07, 1'b1, 1'b0);
      drain("parity_good");
      check("parity_good_data", o_rx_data, 8'h07);
`else
      @(negedge clk);
      check("parity_tied", {7'd0, o_parity_err}, 8'h00);
`endif

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning i_clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port i_clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port i_clr_rx_rdy  input  1  consumer acknowledge; clears o_rx_rdy.
REQ-006 SHALL have port o_rx_data  output  8  last good received byte.
REQ-007 SHALL have port o_rx_rdy  output  1  byte available, level, held until cleared.
REQ-008 SHALL have port o_frame_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-009 SHALL have port o_parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-010 SHALL have port o_overrun  output  1  one-cycle pulse, good byte completed while o_rx_rdy already 1.
REQ-011 Clocking and reset SHALL be exactly: one clock; reset is asynchronous and active-high.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; a third flop holds the previous synced sample for edge detection.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE SHALL arm only on a synced 1->0 transition; a line held low never re-arms.
REQ-015 On arming, baud counter SHALL load CLKS_PER_BIT/2-1 (integer division) and FSM SHALL enter START.
REQ-016 Baud counter SHALL decrement every cycle; the sample point is the cycle it equals 0.
REQ-017 START sample 1 SHALL be a false start: return to IDLE, no flag, no output change.
REQ-018 START sample 0 SHALL load counter CLKS_PER_BIT-1, clear 3-bit bit counter, enter DATA.
REQ-019 DATA SHALL sample 8 bits LSB first, shift register <= {sample, shreg[7:1]}, reload CLKS_PER_BIT-1 after each sample.
REQ-020 After the 8th data sample FSM SHALL enter PARITY (macro) or STOP.
REQ-021 STOP sample 1 with no parity error SHALL register o_rx_data <= shreg and o_rx_rdy <= 1 on the next edge; FSM returns to IDLE.
REQ-022 STOP sample 0 SHALL pulse o_frame_err, leave o_rx_data and o_rx_rdy unchanged, return to IDLE.
REQ-023 End-to-end latency SHALL be 1 cycle from stop-bit sample point to o_rx_rdy high.
REQ-024 i_clr_rx_rdy SHALL clear o_rx_rdy on the next edge; a simultaneous new-byte set SHALL win.
REQ-025 A good byte completing with o_rx_rdy==1 SHALL pulse o_overrun and overwrite o_rx_data.
REQ-026 All flag pulses SHALL be exactly one i_clk cycle, registered.

Reset
REQ-027 i_rst SHALL force IDLE, counters 0, shreg 0x00, o_rx_data 0x00, o_rx_rdy/o_frame_err/o_parity_err/o_overrun 0, and all synchronizer flops 1.
REQ-028 Reset mid-frame SHALL abandon the frame; no partial byte or flag SHALL appear after release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined SHALL add PARITY state sampling one even-parity bit after data; XOR(data, parity bit)!=0 SHALL pulse o_parity_err at the STOP sample point and suppress delivery (o_rx_rdy, o_rx_data unchanged, no o_overrun).
REQ-030 Macro undefined SHALL omit PARITY state; frames are 8N1; o_parity_err SHALL be tied 0; port list unchanged.

Verification (CLKS_PER_BIT=16)
REQ-031 8N1 byte 0xA5 -> o_rx_data=0xA5, o_rx_rdy rises 1 cycle after stop sample (~152 cycles after falling edge + 3 sync), held until i_clr_rx_rdy pulse, low next cycle.
REQ-032 i_rx low for 4 cycles then high -> no flag, o_rx_rdy stays 0; following 0x55 frame received correctly.
REQ-033 0x3C with stop bit 0, then line high and valid 0x55 -> o_frame_err one pulse, o_rx_rdy 0; then o_rx_data=0x55, o_rx_rdy=1.
REQ-034 0x11 then 0x22 back-to-back without clear -> o_overrun one pulse at second byte, o_rx_data=0x22, o_rx_rdy stays 1.
REQ-035 i_rst pulse during bit 4 of 0xFF, line idle 2 bit times, then 0x80 -> only 0x80 delivered, no flags.
REQ-036 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_parity_err one pulse, o_rx_rdy 0; 0x07 with parity bit 1 -> o_rx_data=0x07, o_rx_rdy=1.
